// File: rtl/uart_mmio_bridge.sv
`timescale 1ns/1ps
// uart_mmio_bridge: console target on the core's RAM-style request port.
// TXDATA stores drain through a TX FIFO; RXDATA loads poll uart_in.
module uart_mmio_bridge #(
    parameter logic [63:0] UART_BASE  = 64'h0000_0000_1000_0000,
    parameter int          FIFO_DEPTH = 16,
    parameter int          TX_GAP     = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_ren,
    input  logic [63:0] req_raddr,
    output logic [63:0] req_rdata,
    output logic        rd_hit,
    input  logic        req_wen,
    input  logic [63:0] req_waddr,
    input  logic [63:0] req_wdata,
    input  logic [63:0] req_wmask,
    output logic        uart_out_valid,
    output logic [7:0]  uart_out_ch,
    output logic        uart_in_valid,
    input  logic [7:0]  uart_in_ch
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int GW = (TX_GAP > 0) ? $clog2(TX_GAP + 1) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, SEND, GAP} txState_t;
    txState_t state, stateNext;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wrPtr, rdPtr;
    logic [AW:0]   count;
    logic          drop;
    logic [GW-1:0] gapCnt, gapNext;

    logic        rdHit, wrHit, full, empty;
    logic [1:0]  rdOff, wrOff;
    logic        pop, push, accept, dropSet, statusClr;
    logic [63:0] status;
    logic        unusedBits;

    assign rdHit = req_raddr[63:5] == UART_BASE[63:5];
    assign wrHit = req_waddr[63:5] == UART_BASE[63:5];
    assign rdOff = req_raddr[4:3];
    assign wrOff = req_waddr[4:3];

    assign full   = count == FULL_CNT;
    assign empty  = count == '0;
    assign status = {48'b0, 8'(count), 5'b0, drop, empty, full};

    assign push      = req_wen & wrHit & (wrOff == 2'd0)
                     & (|req_wmask[7:0]);
    assign accept    = push & (~full | pop);
    assign dropSet   = push & full & ~pop;
    assign statusClr = req_wen & wrHit & (wrOff == 2'd1)
                     & (|req_wmask[7:0]);

    assign uart_out_valid = state == SEND;
    assign uart_in_valid  = ~rst & req_ren & rdHit
                          & (rdOff == 2'd2);

    assign unusedBits = ^{req_raddr[2:0], req_waddr[2:0],
                          req_wdata[63:8], req_wmask[63:8]};

    always_comb begin
        stateNext = state;
        gapNext   = gapCnt;
        pop       = 1'b0;
        unique case (state)
            IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    stateNext = SEND;
                end
            end
            SEND: begin
                if (TX_GAP == 0) begin
                    if (!empty) pop = 1'b1;
                    else        stateNext = IDLE;
                end else begin
                    gapNext   = GW'(TX_GAP);
                    stateNext = GAP;
                end
            end
            GAP: begin
                gapNext = gapCnt - GW'(1);
                // last gap cycle may pop directly: exactly TX_GAP quiet cycles
                if (gapCnt <= GW'(1)) begin
                    if (!empty) begin
                        pop       = 1'b1;
                        stateNext = SEND;
                    end else begin
                        stateNext = IDLE;
                    end
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept) mem[wrPtr] <= req_wdata[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            gapCnt      <= '0;
            wrPtr       <= '0;
            rdPtr       <= '0;
            count       <= '0;
            drop        <= 1'b0;
            uart_out_ch <= 8'h00;
            req_rdata   <= '0;
            rd_hit      <= 1'b0;
        end else begin
            state  <= stateNext;
            gapCnt <= gapNext;
            if (accept) wrPtr <= wrPtr + AW'(1);
            if (pop) begin
                uart_out_ch <= mem[rdPtr];
                rdPtr       <= rdPtr + AW'(1);
            end
            unique case ({accept, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
            if (dropSet)        drop <= 1'b1;
            else if (statusClr) drop <= 1'b0;
            rd_hit <= req_ren & rdHit;
            if (req_ren && rdHit) begin
                unique case (rdOff)
                    2'd1:    req_rdata <= status;
                    2'd2:    req_rdata <= {56'b0, uart_in_ch};
                    default: req_rdata <= '0;
                endcase
            end else begin
                req_rdata <= '0;
            end
        end
    end
endmodule

// File: tb/tb_uart_mmio_bridge.sv
`timescale 1ns/1ps
// tb_uart_mmio_bridge: two bridges (TX_GAP 0 and 8) on shared stimulus,
// checked each cycle against a queue model plus literal expectations.
module tb_uart_mmio_bridge;
    localparam logic [63:0] BASE = 64'h0000_0000_1000_0000;
    localparam logic [63:0] TXA  = BASE;
    localparam logic [63:0] STA  = BASE + 64'd8;
    localparam logic [63:0] RXA  = BASE + 64'd16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        req_ren = 1'b0, req_wen = 1'b0;
    logic [63:0] req_raddr = '0, req_waddr = '0;
    logic [63:0] req_wdata = '0, req_wmask = '0;
    logic [7:0]  uart_in_ch = 8'h00;

    logic [63:0] rdata [2];
    logic        hit [2], oValid [2], inValid [2];
    logic [7:0]  oCh [2];

    uart_mmio_bridge #(.UART_BASE(BASE), .FIFO_DEPTH(16), .TX_GAP(0)) dut0 (
        .clk(clk), .rst(rst),
        .req_ren(req_ren), .req_raddr(req_raddr),
        .req_rdata(rdata[0]), .rd_hit(hit[0]),
        .req_wen(req_wen), .req_waddr(req_waddr),
        .req_wdata(req_wdata), .req_wmask(req_wmask),
        .uart_out_valid(oValid[0]), .uart_out_ch(oCh[0]),
        .uart_in_valid(inValid[0]), .uart_in_ch(uart_in_ch));

    uart_mmio_bridge #(.UART_BASE(BASE), .FIFO_DEPTH(16), .TX_GAP(8)) dut8 (
        .clk(clk), .rst(rst),
        .req_ren(req_ren), .req_raddr(req_raddr),
        .req_rdata(rdata[1]), .rd_hit(hit[1]),
        .req_wen(req_wen), .req_waddr(req_waddr),
        .req_wdata(req_wdata), .req_wmask(req_wmask),
        .uart_out_valid(oValid[1]), .uart_out_ch(oCh[1]),
        .uart_in_valid(inValid[1]), .uart_in_ch(uart_in_ch));

    int nCmp = 0;
    int nFail = 0;

    function automatic void chk(string nm, int i,
                                logic [63:0] act, logic [63:0] exp);
        nCmp++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s dut%0d: got %0h expected %0h",
                     nm, i, act, exp);
        end
    endfunction

    // queue model: byte ring, size, sticky drop, last pop cycle
    logic [7:0]  mq [2][16];
    int          mHead [2] = '{0, 0};
    int          mSize [2] = '{0, 0};
    logic        mDrop [2] = '{0, 0};
    int          lastPop [2] = '{-1000, -1000};
    int          cyc = 0;
    logic        eValid [2], eHit [2];
    logic [7:0]  eCh [2];
    logic [63:0] eRdata [2];

    logic [7:0] lch [2][64];
    int         lcy [2][64];
    int         ln [2] = '{0, 0};

    task automatic modelStep(input int i);
        logic [63:0] st;
        logic rh, wh, pp, ps, fl;
        int gap;
        gap = (i == 0) ? 0 : 8;
        if (rst) begin
            mSize[i] = 0; mHead[i] = 0; mDrop[i] = 1'b0;
            lastPop[i] = -1000;
            eValid[i] = 1'b0; eCh[i] = 8'h00;
            eRdata[i] = '0; eHit[i] = 1'b0;
            return;
        end
        st = {48'b0, 8'(mSize[i]), 5'b0, mDrop[i],
              mSize[i] == 0, mSize[i] == 16};
        rh = req_ren && (req_raddr[63:5] == BASE[63:5]);
        eHit[i] = rh;
        if (!rh)                       eRdata[i] = '0;
        else if (req_raddr[4:3] == 1)  eRdata[i] = st;
        else if (req_raddr[4:3] == 2)  eRdata[i] = {56'b0, uart_in_ch};
        else                           eRdata[i] = '0;
        wh = req_wen && (req_waddr[63:5] == BASE[63:5])
             && (req_wmask[7:0] != 0);
        ps = wh && (req_waddr[4:3] == 0);
        if (wh && req_waddr[4:3] == 1) mDrop[i] = 1'b0;
        fl = mSize[i] == 16;
        pp = (mSize[i] > 0) && (cyc >= lastPop[i] + gap + 1);
        eValid[i] = pp;
        if (pp) begin
            eCh[i] = mq[i][mHead[i]];
            mHead[i] = (mHead[i] + 1) % 16;
            mSize[i]--;
            lastPop[i] = cyc;
        end
        if (ps) begin
            if (!fl || pp) begin
                mq[i][(mHead[i] + mSize[i]) % 16] = req_wdata[7:0];
                mSize[i]++;
            end else begin
                mDrop[i] = 1'b1;
            end
        end
    endtask

    always @(posedge clk) begin
        logic eIn;
        for (int i = 0; i < 2; i++) modelStep(i);
        cyc++;
        #1;
        eIn = !rst && req_ren && (req_raddr[63:5] == BASE[63:5])
              && (req_raddr[4:3] == 2);
        for (int i = 0; i < 2; i++) begin
            chk("out_valid", i, 64'(oValid[i]), 64'(eValid[i]));
            chk("out_ch", i, 64'(oCh[i]), 64'(eCh[i]));
            chk("rdata", i, rdata[i], eRdata[i]);
            chk("rd_hit", i, 64'(hit[i]), 64'(eHit[i]));
            chk("in_valid", i, 64'(inValid[i]), 64'(eIn));
            if (oValid[i] === 1'b1 && ln[i] < 64) begin
                lch[i][ln[i]] = oCh[i];
                lcy[i][ln[i]] = cyc;
                ln[i]++;
            end
        end
    end

    logic [63:0] rd [2];
    logic        rh [2], inReq [2];

    task automatic drive(input logic r, input logic [63:0] ra,
                         input logic w, input logic [63:0] wa,
                         input logic [63:0] wd, input logic [63:0] wm);
        req_ren = r; req_raddr = ra;
        req_wen = w; req_waddr = wa;
        req_wdata = wd; req_wmask = wm;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            drive(0, '0, 0, '0, '0, '0);
        end
    endtask

    task automatic wr(input logic [63:0] a, input logic [63:0] d,
                      input logic [63:0] m);
        @(negedge clk);
        drive(0, '0, 1, a, d, m);
    endtask

    task automatic rdwr(input logic [63:0] ra, input logic w,
                        input logic [63:0] wa, input logic [63:0] wd,
                        input logic [63:0] wm);
        @(negedge clk);
        drive(1, ra, w, wa, wd, wm);
        #1;
        inReq[0] = inValid[0]; inReq[1] = inValid[1];
        @(negedge clk);
        drive(0, '0, 0, '0, '0, '0);
        rd[0] = rdata[0]; rd[1] = rdata[1];
        rh[0] = hit[0];   rh[1] = hit[1];
    endtask

    task automatic doRead(input logic [63:0] a);
        rdwr(a, 0, '0, '0, '0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not end");
        $fatal(1, "watchdog");
    end

    initial begin
        logic done, seen;
        int nW;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle(1);
        doRead(STA);
        chk("status_reset", 0, rd[0], 64'h2);
        chk("status_reset", 1, rd[1], 64'h2);

        ln = '{0, 0};
        wr(TXA, 64'h41, 64'hFF);
        wr(TXA, 64'h42, 64'hFF);
        idle(6);
        chk("b2b_count", 0, 64'(ln[0]), 64'd2);
        chk("b2b_ch0", 0, 64'(lch[0][0]), 64'h41);
        chk("b2b_ch1", 0, 64'(lch[0][1]), 64'h42);
        chk("b2b_gap", 0, 64'(lcy[0][1] - lcy[0][0]), 64'd1);
        doRead(STA);
        chk("status_idle", 0, rd[0], 64'h2);
        idle(25);

        ln = '{0, 0};
        for (int k = 0; k < 19; k++) wr(TXA, 64'(k), 64'hFF);
        doRead(STA);
        chk("drop_set", 1, 64'(rd[1][2]), 64'd1);
        chk("drop_none", 0, 64'(rd[0][2]), 64'd0);
        wr(STA, 64'h0, 64'hFF);
        doRead(STA);
        chk("drop_clr", 1, 64'(rd[1][2]), 64'd0);
        idle(180);
        chk("gap_count", 1, 64'(ln[1]), 64'd18);
        chk("nogap_count", 0, 64'(ln[0]), 64'd19);
        for (int j = 0; j < 18; j++) begin
            chk("gap_ch", 1, 64'(lch[1][j]), 64'(j));
            if (j > 0)
                chk("gap_space", 1, 64'(lcy[1][j] - lcy[1][j-1]), 64'd9);
        end

        ln = '{0, 0};
        done = 1'b0;
        nW = 0;
        for (int k = 0; k < 120 && !done; k++) begin
            @(negedge clk);
            if (mSize[1] == 16 && cyc >= lastPop[1] + 9) begin
                drive(0, '0, 1, TXA, 64'h55, 64'hFF);
                nW++;
                done = 1'b1;
            end else if (mSize[1] < 16) begin
                drive(0, '0, 1, TXA, 64'(8'h20 + nW), 64'hFF);
                nW++;
            end else begin
                drive(0, '0, 0, '0, '0, '0);
            end
        end
        chk("full_pop_reached", 1, 64'(done), 64'd1);
        idle(1);
        doRead(STA);
        chk("full_pop_nodrop", 1, 64'(rd[1][2]), 64'd0);
        idle(200);
        chk("full_pop_count", 1, 64'(ln[1]), 64'(nW));
        chk("full_pop_last", 1, 64'(lch[1][ln[1] - 1]), 64'h55);

        uart_in_ch = 8'h7A;
        doRead(RXA);
        chk("rx_req", 0, 64'(inReq[0]), 64'd1);
        chk("rx_data", 0, rd[0], 64'h7A);
        chk("rx_hit", 1, 64'(rh[1]), 64'd1);
        uart_in_ch = 8'hFF;
        doRead(RXA);
        chk("rx_none", 1, rd[1], 64'hFF);
        doRead(TXA);
        chk("tx_rd_noreq", 0, 64'(inReq[0]), 64'd0);
        chk("tx_rd_zero", 0, rd[0], 64'h0);

        ln = '{0, 0};
        rdwr(BASE + 64'h40, 1, BASE - 64'd8, 64'h33, 64'hFF);
        chk("oow_hit", 0, 64'(rh[0]), 64'd0);
        chk("oow_data", 1, rd[1], 64'h0);
        chk("oow_req", 1, 64'(inReq[1]), 64'd0);
        wr(TXA, 64'h99, 64'h0);
        idle(3);
        doRead(STA);
        chk("oow_status", 0, rd[0], 64'h2);
        chk("oow_status", 1, rd[1], 64'h2);
        chk("oow_quiet", 0, 64'(ln[0]), 64'd0);
        chk("oow_quiet", 1, 64'(ln[1]), 64'd0);

        for (int k = 0; k < 7; k++) wr(TXA, 64'(8'h60 + k), 64'hFF);
        idle(1);
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (oValid[1] === 1'b1) seen = 1'b1;
        end
        chk("send_seen", 1, 64'(seen), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_valid", 0, 64'(oValid[0]), 64'd0);
        chk("rst_valid", 1, 64'(oValid[1]), 64'd0);
        rst = 1'b0;
        ln = '{0, 0};
        doRead(STA);
        chk("rst_status", 0, rd[0], 64'h2);
        chk("rst_status", 1, rd[1], 64'h2);
        idle(30);
        chk("rst_quiet", 0, 64'(ln[0]), 64'd0);
        chk("rst_quiet", 1, 64'(ln[1]), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 nCmp, nFail);
        $finish;
    end
endmodule
